mat_operand_loader: RTL and testbench
=====================================

Name: mat_operand_loader

Overview:
Upstream feeder for the parallel matrix multiplier. It accepts a byte-serial stream of operand elements, A first and then B, over a valid/ready handshake. It packs the elements into flat row-major buses in the multiplier's byte order, then holds them stable and drives the multiplier's active-low load strobe until the consumer acknowledges.

Parameters:
A_ROW, 2, rows of matrix A
A_COL, 2, columns of matrix A
B_ROW, 2, rows of matrix B
B_COL, 2, columns of matrix B
A_LEN, A_ROW*A_COL*8, width of the packed A bus (localparam, derived)
B_LEN, B_ROW*B_COL*8, width of the packed B bus (localparam, derived)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-low reset
in_data  input  8  operand element, signed 8-bit
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts in_data this cycle
a_mat  output  A_LEN  packed A; element (r,c) at bits [8*(A_N-1-(r*A_COL+c)) +: 8], A_N=A_ROW*A_COL
b_mat  output  B_LEN  packed B; same packing with B_N=B_ROW*B_COL
out_valid  output  1  a_mat/b_mat complete and stable
out_ack  input  1  consumer has taken the operands
mm_load_n  output  1  equals ~out_valid; drives the multiplier's active-low load input
conf_err  output  1  constant 1 when A_COL != B_ROW
in_last  input  1  only with MAT_LOADER_ERR_EN; marks the final B element
frame_err  output  1  only with MAT_LOADER_ERR_EN; sticky framing error

Behaviour:
- Clocking and reset: reset is rst, synchronous, active-low; clock is clk.
- Reset (rst==0 at posedge):
  - state=LOAD_A, element index idx=0.
  - a_mat=0, b_mat=0, out_valid=0, so mm_load_n=1.
- States are LOAD_A, LOAD_B and HOLD. in_ready is a combinational decode: 1 in LOAD_A and LOAD_B, 0 in HOLD.
- Transfer: occurs when in_valid && in_ready at a posedge. in_data is written into slot idx of the current matrix; the first element received lands in the top byte.
- LOAD_A:
  - On a transfer with idx<A_N-1: idx++.
  - On a transfer with idx==A_N-1: idx=0, state->LOAD_B.
- LOAD_B:
  - On a transfer with idx<B_N-1: idx++.
  - On a transfer with idx==B_N-1: idx=0, state->HOLD, out_valid<=1.
- Latency: if the last B byte is accepted at edge k, out_valid=1 and mm_load_n=0 from k+1.
- HOLD:
  - a_mat and b_mat do not change.
  - in_valid is ignored, and no data is consumed.
  - out_ack=1 at an edge: state->LOAD_A, out_valid<=0, and in_ready=1 from the next cycle.
- out_ack while not in HOLD: ignored.
- Buses are not cleared on reload. Each byte is overwritten as it arrives, and values are meaningful only while out_valid=1.
- in_valid low mid-frame: idx holds, with no timeout.
- Reset mid-frame: the partial frame is discarded, buses go to 0, and loading restarts with A element 0.
- Configuration error: A_COL != B_ROW makes conf_err=1 permanently and forces in_ready=0, so the loader accepts nothing. When A_COL == B_ROW, conf_err=0.
- Widths: elements pass through unmodified with no sign extension. idx is $clog2(max(A_N,B_N))+1 bits.

Optional Feature:
MAT_LOADER_ERR_EN
- Defined:
  - Adds in_last and frame_err.
  - frame_err is set when a transfer has in_last=1 but is not the final B element, or the final B element arrives with in_last=0.
  - On a framing error the current frame is dropped: state->LOAD_A, idx=0, and HOLD is not entered.
  - frame_err stays set until reset.
- Undefined: neither port exists, and the frame length is implied purely by the A_N+B_N count.

Test Plan:
1. 2x2 default, A bytes 01,02,03,04 then B bytes 05,06,07,08 on consecutive cycles -> a_mat=32'h01020304, b_mat=32'h05060708; out_valid=1 and mm_load_n=0 on the cycle after the 8th transfer; in_ready=0.
2. Same data with in_valid toggling 1/0 every cycle, plus out_ack pulsed while in LOAD_B -> identical buses, out_valid delayed only by the idle cycles, and the early ack has no effect.
3. In HOLD, in_valid=1 with data FF for 3 cycles, then out_ack=1 -> buses unchanged during HOLD; after the ack out_valid=0, in_ready=1, and the next byte 0A lands in a_mat[31:24].
4. Reset (rst=0) after 3 A bytes -> a_mat=0 and b_mat=0; the next 8 bytes 11..18 give a_mat=32'h11121314, b_mat=32'h15161718.
5. A_ROW=2, A_COL=3, B_ROW=3, B_COL=1, sending bytes 1..6 then 7,8,9 -> a_mat=48'h010203040506, b_mat=24'h070809; a second instance with B_ROW=2 gives conf_err=1 and in_ready=0 permanently.
6. With MAT_LOADER_ERR_EN, 2x2 with in_last=1 on the 7th byte -> frame_err=1, out_valid stays 0, and the next 8 bytes load normally.

Source files
------------

// File: rtl/mat_operand_loader_if.sv
// Handshake/bus bundle between the byte-serial operand source and the loader.
// Optional MAT_LOADER_ERR_EN adds the in_last framing marker and frame_err flag.
interface mat_operand_loader_if #(
  parameter int A_LEN = 32,
  parameter int B_LEN = 32
) ();
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [A_LEN-1:0] a_mat;
  logic [B_LEN-1:0] b_mat;
  logic             out_valid;
  logic             out_ack;
  logic             mm_load_n;
  logic             conf_err;
`ifdef MAT_LOADER_ERR_EN
  logic             in_last;
  logic             frame_err;

  modport slave (
    input  in_data, in_valid, out_ack, in_last,
    output in_ready, a_mat, b_mat, out_valid, mm_load_n, conf_err, frame_err
  );
  modport master (
    output in_data, in_valid, out_ack, in_last,
    input  in_ready, a_mat, b_mat, out_valid, mm_load_n, conf_err, frame_err
  );
`else
  modport slave (
    input  in_data, in_valid, out_ack,
    output in_ready, a_mat, b_mat, out_valid, mm_load_n, conf_err
  );
  modport master (
    output in_data, in_valid, out_ack,
    input  in_ready, a_mat, b_mat, out_valid, mm_load_n, conf_err
  );
`endif
endinterface

// File: rtl/mat_operand_loader.sv
// Packs a byte stream (A then B) into row-major buses and holds them for the multiplier.
// Optional framing check enabled by defining MAT_LOADER_ERR_EN.
module mat_operand_loader #(
  parameter int A_ROW = 2,
  parameter int A_COL = 2,
  parameter int B_ROW = 2,
  parameter int B_COL = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mat_operand_loader_if.slave  bus
);
  localparam int A_N   = A_ROW * A_COL;
  localparam int B_N   = B_ROW * B_COL;
  localparam int A_LEN = A_N * 8;
  localparam int B_LEN = B_N * 8;
  localparam int MAX_N = (A_N > B_N) ? A_N : B_N;
  localparam int IDX_W = $clog2(MAX_N) + 1;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [A_LEN-1:0] r_a_mat;
  logic [B_LEN-1:0] r_b_mat;
  logic             r_out_valid;
  logic             w_conf_err;
  logic             w_in_ready;
  logic             w_xfer;
  logic             w_last_a;
  logic             w_last_b;
  logic             w_frame_drop;

  assign w_conf_err = (A_COL != B_ROW);
  assign w_xfer     = bus.in_valid && w_in_ready;
  assign w_last_a   = (r_idx == IDX_W'(A_N - 1));
  assign w_last_b   = (r_idx == IDX_W'(B_N - 1));

`ifdef MAT_LOADER_ERR_EN
  logic r_frame_err;

  // in_last must coincide exactly with the final B element, otherwise the frame is dropped
  assign w_frame_drop = w_xfer && (bus.in_last != ((r_state == LOAD_B) && w_last_b));

  always_ff @(posedge clk) begin
    if (!rst)
      r_frame_err <= 1'b0;
    else if (w_frame_drop)
      r_frame_err <= 1'b1;
  end

  assign bus.frame_err = r_frame_err;
`else
  assign w_frame_drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= LOAD_A;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD_A:  if (w_xfer && w_last_a) w_state_next = LOAD_B;
      LOAD_B:  if (w_xfer && w_last_b) w_state_next = HOLD;
      HOLD:    if (bus.out_ack)        w_state_next = LOAD_A;
      default: w_state_next = LOAD_A;
    endcase
    if (w_frame_drop)
      w_state_next = LOAD_A;
  end

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      LOAD_A, LOAD_B: w_in_ready = !w_conf_err;
      default:        w_in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_state_next == HOLD);
      if (w_xfer) begin
        if (w_frame_drop || (r_state == LOAD_A && w_last_a) || (r_state == LOAD_B && w_last_b))
          r_idx <= '0;
        else
          r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Slot 0 is the most significant byte so the first element sent lands on top
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a_mat <= '0;
      r_b_mat <= '0;
    end else if (w_xfer) begin
      for (int i = 0; i < A_N; i++)
        if (r_state == LOAD_A && r_idx == IDX_W'(i))
          r_a_mat[8*(A_N-1-i) +: 8] <= bus.in_data;
      for (int i = 0; i < B_N; i++)
        if (r_state == LOAD_B && r_idx == IDX_W'(i))
          r_b_mat[8*(B_N-1-i) +: 8] <= bus.in_data;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.a_mat     = r_a_mat;
  assign bus.b_mat     = r_b_mat;
  assign bus.out_valid = r_out_valid;
  assign bus.mm_load_n = ~r_out_valid;
  assign bus.conf_err  = w_conf_err;
endmodule

// File: tb/tb_mat_operand_loader.sv
// Directed bench for mat_operand_loader: 2x2 default, 2x3*3x1 shape and a mismatched-shape instance.
// Framing-error steps only run when MAT_LOADER_ERR_EN is defined.
module tb_mat_operand_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mat_operand_loader_if #(.A_LEN(32), .B_LEN(32)) bus0 ();
  mat_operand_loader_if #(.A_LEN(48), .B_LEN(24)) bus1 ();
  mat_operand_loader_if #(.A_LEN(48), .B_LEN(16)) bus2 ();

  mat_operand_loader #(.A_ROW(2), .A_COL(2), .B_ROW(2), .B_COL(2)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  mat_operand_loader #(.A_ROW(2), .A_COL(3), .B_ROW(3), .B_COL(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  mat_operand_loader #(.A_ROW(2), .A_COL(3), .B_ROW(2), .B_COL(1)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) begin
      $display("[TB] ok   %s obs=%0h", tag, obs);
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid cycle on bus0; caller decides whether valid stays high afterwards
  task automatic send0(input logic [7:0] d, input logic last);
    bus0.in_data  = d;
    bus0.in_valid = 1'b1;
`ifdef MAT_LOADER_ERR_EN
    bus0.in_last  = last;
`else
    if (last) begin end
`endif
    tick();
  endtask

  initial begin
    bus0.in_data = '0; bus0.in_valid = 1'b0; bus0.out_ack = 1'b0;
    bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.out_ack = 1'b0;
    bus2.in_data = '0; bus2.in_valid = 1'b0; bus2.out_ack = 1'b0;
`ifdef MAT_LOADER_ERR_EN
    bus0.in_last = 1'b0; bus1.in_last = 1'b0; bus2.in_last = 1'b0;
`endif

    // Reset state
    tick(); tick();
    check("rst_a_mat", bus0.a_mat, 32'h0);
    check("rst_b_mat", bus0.b_mat, 32'h0);
    check("rst_out_valid", bus0.out_valid, 1'b0);
    check("rst_mm_load_n", bus0.mm_load_n, 1'b1);
    check("rst_in_ready", bus0.in_ready, 1'b1);
    check("rst_conf_err", bus0.conf_err, 1'b0);
    rst = 1'b1;

    // Back-to-back frame 01..08
    for (int i = 1; i <= 8; i++) begin
      send0(8'(i), i == 8);
      if (i == 7) check("t1_no_early_valid", bus0.out_valid, 1'b0);
    end
    bus0.in_valid = 1'b0;
    check("t1_out_valid", bus0.out_valid, 1'b1);
    check("t1_mm_load_n", bus0.mm_load_n, 1'b0);
    check("t1_in_ready", bus0.in_ready, 1'b0);
    check("t1_a_mat", bus0.a_mat, 32'h01020304);
    check("t1_b_mat", bus0.b_mat, 32'h05060708);

    // HOLD ignores incoming data until acknowledged
    for (int i = 0; i < 3; i++) begin
      send0(8'hFF, 1'b0);
      check("t3_hold_a", bus0.a_mat, 32'h01020304);
      check("t3_hold_b", bus0.b_mat, 32'h05060708);
    end
    bus0.in_valid = 1'b0;
    bus0.out_ack  = 1'b1;
    tick();
    bus0.out_ack  = 1'b0;
    check("t3_ack_out_valid", bus0.out_valid, 1'b0);
    check("t3_ack_in_ready", bus0.in_ready, 1'b1);
    check("t3_ack_mm_load_n", bus0.mm_load_n, 1'b1);
    send0(8'h0A, 1'b0);
    bus0.in_valid = 1'b0;
    check("t3_reload_top", bus0.a_mat[31:24], 8'h0A);

    // Reset mid-frame after 3 A bytes, then a fresh frame 11..18
    send0(8'h0B, 1'b0);
    send0(8'h0C, 1'b0);
    bus0.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t4_rst_a", bus0.a_mat, 32'h0);
    check("t4_rst_b", bus0.b_mat, 32'h0);
    check("t4_rst_out_valid", bus0.out_valid, 1'b0);
    for (int i = 0; i < 8; i++) send0(8'(8'h11 + i), i == 7);
    bus0.in_valid = 1'b0;
    check("t4_out_valid", bus0.out_valid, 1'b1);
    check("t4_a_mat", bus0.a_mat, 32'h11121314);
    check("t4_b_mat", bus0.b_mat, 32'h15161718);
    bus0.out_ack = 1'b1;
    tick();
    bus0.out_ack = 1'b0;

    // Valid toggling, with an early ack during LOAD_B
    for (int i = 1; i <= 8; i++) begin
      send0(8'(i), i == 8);
      bus0.in_valid = 1'b0;
      if (i == 8) break;
      bus0.out_ack = (i == 5);
      tick();
      bus0.out_ack = 1'b0;
      if (i == 7) check("t2_no_early_valid", bus0.out_valid, 1'b0);
    end
    check("t2_out_valid", bus0.out_valid, 1'b1);
    check("t2_a_mat", bus0.a_mat, 32'h01020304);
    check("t2_b_mat", bus0.b_mat, 32'h05060708);
    bus0.out_ack = 1'b1;
    tick();
    bus0.out_ack = 1'b0;
    check("t2_ack_out_valid", bus0.out_valid, 1'b0);

    // 2x3 * 3x1 shape, and a mismatched shape that must accept nothing
    check("t5_conf_ok", bus1.conf_err, 1'b0);
    check("t5_conf_err", bus2.conf_err, 1'b1);
    bus2.in_valid = 1'b1;
    bus2.in_data  = 8'h5A;
    for (int i = 1; i <= 9; i++) begin
      bus1.in_data  = 8'(i);
      bus1.in_valid = 1'b1;
      tick();
      check("t5_bad_in_ready", bus2.in_ready, 1'b0);
    end
    bus1.in_valid = 1'b0;
    check("t5_out_valid", bus1.out_valid, 1'b1);
    check("t5_a_mat", bus1.a_mat, 48'h010203040506);
    check("t5_b_mat", bus1.b_mat, 24'h070809);
    check("t5_bad_out_valid", bus2.out_valid, 1'b0);
    check("t5_bad_a_mat", bus2.a_mat, 48'h0);

`ifdef MAT_LOADER_ERR_EN
    // in_last on the 7th byte drops the frame; the next frame loads normally
    check("t6_rst_frame_err", bus0.frame_err, 1'b0);
    for (int i = 1; i <= 7; i++) send0(8'(i), i == 7);
    bus0.in_valid = 1'b0;
    check("t6_frame_err", bus0.frame_err, 1'b1);
    tick();
    check("t6_no_valid", bus0.out_valid, 1'b0);
    check("t6_in_ready", bus0.in_ready, 1'b1);
    for (int i = 0; i < 8; i++) send0(8'(8'h21 + i), i == 7);
    bus0.in_valid = 1'b0;
    check("t6_out_valid", bus0.out_valid, 1'b1);
    check("t6_a_mat", bus0.a_mat, 32'h21222324);
    check("t6_b_mat", bus0.b_mat, 32'h25262728);
    check("t6_sticky", bus0.frame_err, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
